// File: rtl/datapath_pkg.sv
// Shared constants and FSM state type for the pipelined datapath register file.
package datapath_pkg;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int WRC_W = 16;
    localparam int DRC_W = 8;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;
endpackage

// File: rtl/reg_file_mem.sv
// Register storage: one synchronous write port, two asynchronous read ports.
// No reset here, so the array can map onto distributed RAM.
module reg_file_mem #(
    parameter int NREGS = datapath_pkg::NREGS,
    parameter int AW    = datapath_pkg::AW,
    parameter int DW    = datapath_pkg::DW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2
);
    logic [DW-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file with stage-3 write-back, post-reset clear sweep,
// same-cycle bypass, registered write echo and commit/drop counters.
module reg_file_wb #(
    parameter int NREGS  = datapath_pkg::NREGS,
    parameter int AW     = datapath_pkg::AW,
    parameter int DW     = datapath_pkg::DW,
    parameter bit BYPASS = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           S3_WE,
    input  logic [AW-1:0]                  S3_WS,
    input  logic [DW-1:0]                  S3_data,
    input  logic [AW-1:0]                  rs1_addr,
    input  logic [AW-1:0]                  rs2_addr,
    output logic [DW-1:0]                  rs1_data,
    output logic [DW-1:0]                  rs2_data,
    output logic                           ready,
    output logic                           chk_we,
    output logic [AW-1:0]                  chk_ws,
    output logic [DW-1:0]                  chk_data,
    output logic [datapath_pkg::WRC_W-1:0] wr_count,
    output logic [datapath_pkg::DRC_W-1:0] drop_count
);
    import datapath_pkg::*;

    state_e           r_state;
    logic [AW-1:0]    r_clrPtr;
    logic             r_chkWe;
    logic [AW-1:0]    r_chkWs;
    logic [DW-1:0]    r_chkData;
    logic [WRC_W-1:0] r_wrCount;
    logic [DRC_W-1:0] r_dropCount;

    logic             w_commit;
    logic             w_drop;
    logic             w_memWe;
    logic [AW-1:0]    w_memAddr;
    logic [DW-1:0]    w_memData;
    logic [DW-1:0]    w_rdData1;
    logic [DW-1:0]    w_rdData2;

    // rst overrides everything in the same cycle: no commit, no drop count.
    assign w_commit  = !rst && (r_state == RUN) && S3_WE && (S3_WS != '0);
    assign w_drop    = !rst && (r_state == CLEAR) && S3_WE;
    assign w_memWe   = !rst && ((r_state == CLEAR) || w_commit);
    assign w_memAddr = (r_state == CLEAR) ? r_clrPtr : S3_WS;
    assign w_memData = (r_state == CLEAR) ? '0 : S3_data;

    reg_file_mem #(
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk      (clk),
        .i_we     (w_memWe),
        .i_waddr  (w_memAddr),
        .i_wdata  (w_memData),
        .i_raddr1 (rs1_addr),
        .i_raddr2 (rs2_addr),
        .o_rdata1 (w_rdData1),
        .o_rdata2 (w_rdData2)
    );

    always_comb begin
        rs1_data = w_rdData1;
        if ((r_state == CLEAR) || (rs1_addr == '0)) begin
            rs1_data = '0;
        end else if (BYPASS && w_commit && (S3_WS == rs1_addr)) begin
            rs1_data = S3_data;
        end
    end

    always_comb begin
        rs2_data = w_rdData2;
        if ((r_state == CLEAR) || (rs2_addr == '0)) begin
            rs2_data = '0;
        end else if (BYPASS && w_commit && (S3_WS == rs2_addr)) begin
            rs2_data = S3_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_clrPtr    <= '0;
            r_chkWe     <= 1'b0;
            r_chkWs     <= '0;
            r_chkData   <= '0;
            r_wrCount   <= '0;
            r_dropCount <= '0;
        end else begin
            r_chkWe <= w_commit;
            if (w_commit) begin
                r_chkWs   <= S3_WS;
                r_chkData <= S3_data;
                r_wrCount <= r_wrCount + WRC_W'(1);
            end
            // Sweep leaves CLEAR on the edge that zeroes the last entry.
            if (r_state == CLEAR) begin
                r_clrPtr <= r_clrPtr + AW'(1);
                if (r_clrPtr == AW'(NREGS - 1)) begin
                    r_state <= RUN;
                end
                if (w_drop && (r_dropCount != '1)) begin
                    r_dropCount <= r_dropCount + DRC_W'(1);
                end
            end
        end
    end

    assign ready      = (r_state == RUN);
    assign chk_we     = r_chkWe;
    assign chk_ws     = r_chkWs;
    assign chk_data   = r_chkData;
    assign wr_count   = r_wrCount;
    assign drop_count = r_dropCount;
endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: echo scoreboard plus a reference register model,
// with a second instance built without bypass for the forwarding comparison.
`timescale 1ns/1ps
module tb_reg_file_wb;
    import datapath_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s3We = 1'b0;
    logic [AW-1:0]    s3Ws = '0;
    logic [DW-1:0]    s3Data = '0;
    logic [AW-1:0]    rs1Addr = '0;
    logic [AW-1:0]    rs2Addr = '0;

    logic [DW-1:0]    rs1Data, rs2Data, rs1DataNb, rs2DataNb;
    logic             ready, readyNb, chkWe, chkWeNb;
    logic [AW-1:0]    chkWs, chkWsNb;
    logic [DW-1:0]    chkData, chkDataNb;
    logic [WRC_W-1:0] wrCount, wrCountNb;
    logic [DRC_W-1:0] dropCount, dropCountNb;

    typedef struct {
        logic [AW-1:0] ws;
        logic [DW-1:0] data;
    } echo_t;

    echo_t         echoQ[$];
    echo_t         echoHead;
    logic [DW-1:0] refMem [NREGS];
    int            expWr = 0;
    int            assertCount = 0;
    int            failCount = 0;

    always #5 clk = ~clk;

    reg_file_wb #(.NREGS(NREGS), .AW(AW), .DW(DW), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .S3_WE(s3We), .S3_WS(s3Ws), .S3_data(s3Data),
        .rs1_addr(rs1Addr), .rs2_addr(rs2Addr), .rs1_data(rs1Data), .rs2_data(rs2Data),
        .ready(ready), .chk_we(chkWe), .chk_ws(chkWs), .chk_data(chkData),
        .wr_count(wrCount), .drop_count(dropCount)
    );

    reg_file_wb #(.NREGS(NREGS), .AW(AW), .DW(DW), .BYPASS(1'b0)) dutNb (
        .clk(clk), .rst(rst), .S3_WE(s3We), .S3_WS(s3Ws), .S3_data(s3Data),
        .rs1_addr(rs1Addr), .rs2_addr(rs2Addr), .rs1_data(rs1DataNb), .rs2_data(rs2DataNb),
        .ready(readyNb), .chk_we(chkWeNb), .chk_ws(chkWsNb), .chk_data(chkDataNb),
        .wr_count(wrCountNb), .drop_count(dropCountNb)
    );

    // Every echo seen mid-cycle must match the oldest committed write still outstanding.
    always @(negedge clk) begin
        if (chkWe === 1'b1) begin
            assertCount++;
            if (echoQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL echo_unexpected: got ws=%0d data=%h, required no echo", chkWs, chkData);
            end else begin
                echoHead = echoQ.pop_front();
                if (chkWs !== echoHead.ws || chkData !== echoHead.data) begin
                    failCount++;
                    $display("[TB] FAIL echo_scoreboard: got ws=%0d data=%h, required ws=%0d data=%h",
                             chkWs, chkData, echoHead.ws, echoHead.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst  = 1'b1;
        s3We = 1'b0;
        step();
        rst = 1'b0;
        echoQ.delete();
        for (int i = 0; i < NREGS; i++) refMem[i] = '0;
        expWr = 0;
    endtask

    task automatic waitReady(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic writeCycle(input logic [AW-1:0] ws, input logic [DW-1:0] data);
        s3We   = 1'b1;
        s3Ws   = ws;
        s3Data = data;
        if (ws != '0) echoQ.push_back('{ws: ws, data: data});
        step();
        s3We = 1'b0;
        if (ws != '0) begin
            refMem[ws] = data;
            expWr++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        doReset();
        assertCount++;
        if (ready !== 1'b0 || chkWe !== 1'b0 || chkWs !== '0 || chkData !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got ready=%b chk_we=%b chk_ws=%0d chk_data=%h, required all 0",
                     ready, chkWe, chkWs, chkData);
        end
        assertCount++;
        if (wrCount !== 16'd0 || dropCount !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL reset_counters: got wr=%0d drop=%0d, required 0 0", wrCount, dropCount);
        end
        rs1Addr = 5'd1;
        #1;
        assertCount++;
        if (rs1Data !== '0) begin
            failCount++;
            $display("[TB] FAIL clear_read_zero: got %h, required 0", rs1Data);
        end
        waitReady(cycles);
        assertCount++;
        if (cycles !== 32) begin
            failCount++;
            $display("[TB] FAIL sweep_length: got %0d cycles, required 32", cycles);
        end
        for (int r = 1; r < NREGS; r++) begin
            rs1Addr = AW'(r);
            rs2Addr = AW'(r);
            #1;
            assertCount++;
            if (rs1Data !== refMem[r] || rs2Data !== refMem[r]) begin
                failCount++;
                $display("[TB] FAIL sweep_read_r%0d: got %h/%h, required %h", r, rs1Data, rs2Data, refMem[r]);
            end
        end
        assertCount++;
        if (wrCount !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL sweep_wr_count: got %0d, required 0", wrCount);
        end
    endtask

    task automatic test_write_during_clear();
        int cycles;
        doReset();
        step();
        step();
        s3We   = 1'b1;
        s3Ws   = 5'd5;
        s3Data = 32'hDEADBEEF;
        step();
        s3We = 1'b0;
        assertCount++;
        if (dropCount !== 8'd1) begin
            failCount++;
            $display("[TB] FAIL clear_drop_count: got %0d, required 1", dropCount);
        end
        waitReady(cycles);
        assertCount++;
        if (cycles !== 29) begin
            failCount++;
            $display("[TB] FAIL clear_remaining_sweep: got %0d cycles, required 29", cycles);
        end
        rs1Addr = 5'd5;
        #1;
        assertCount++;
        if (rs1Data !== refMem[5] || rs1DataNb !== refMem[5]) begin
            failCount++;
            $display("[TB] FAIL clear_write_dropped: got %h/%h, required %h", rs1Data, rs1DataNb, refMem[5]);
        end
        assertCount++;
        if (wrCount !== 16'd0 || dropCount !== 8'd1) begin
            failCount++;
            $display("[TB] FAIL clear_counters: got wr=%0d drop=%0d, required 0 1", wrCount, dropCount);
        end
    endtask

    task automatic test_write_echo();
        rs1Addr = 5'd7;
        writeCycle(5'd7, 32'h12345678);
        assertCount++;
        if (chkWe !== 1'b1 || chkWs !== 5'd7 || chkData !== 32'h12345678) begin
            failCount++;
            $display("[TB] FAIL echo_basic: got we=%b ws=%0d data=%h, required 1 7 12345678",
                     chkWe, chkWs, chkData);
        end
        assertCount++;
        if (rs1Data !== refMem[7]) begin
            failCount++;
            $display("[TB] FAIL read_after_write: got %h, required %h", rs1Data, refMem[7]);
        end
        assertCount++;
        if (wrCount !== 16'(expWr)) begin
            failCount++;
            $display("[TB] FAIL write_count_basic: got %0d, required %0d", wrCount, expWr);
        end
    endtask

    task automatic test_bypass();
        rs1Addr = 5'd7;
        rs2Addr = 5'd9;
        s3We    = 1'b1;
        s3Ws    = 5'd9;
        s3Data  = 32'hA5A5A5A5;
        echoQ.push_back('{ws: 5'd9, data: 32'hA5A5A5A5});
        #1;
        assertCount++;
        if (rs2Data !== 32'hA5A5A5A5) begin
            failCount++;
            $display("[TB] FAIL bypass_on: got %h, required a5a5a5a5", rs2Data);
        end
        assertCount++;
        if (rs2DataNb !== refMem[9]) begin
            failCount++;
            $display("[TB] FAIL bypass_off: got %h, required %h", rs2DataNb, refMem[9]);
        end
        assertCount++;
        if (rs1Data !== refMem[7]) begin
            failCount++;
            $display("[TB] FAIL bypass_other_port: got %h, required %h", rs1Data, refMem[7]);
        end
        step();
        s3We = 1'b0;
        refMem[9] = 32'hA5A5A5A5;
        expWr++;
        assertCount++;
        if (rs2Data !== refMem[9] || rs2DataNb !== refMem[9]) begin
            failCount++;
            $display("[TB] FAIL bypass_committed: got %h/%h, required %h", rs2Data, rs2DataNb, refMem[9]);
        end
    endtask

    task automatic test_r0_back_to_back();
        rs1Addr = 5'd0;
        s3We    = 1'b1;
        s3Ws    = 5'd0;
        s3Data  = 32'hFFFFFFFF;
        #1;
        assertCount++;
        if (rs1Data !== '0) begin
            failCount++;
            $display("[TB] FAIL r0_read: got %h, required 0", rs1Data);
        end
        step();
        s3We = 1'b0;
        assertCount++;
        if (chkWe !== 1'b0 || wrCount !== 16'(expWr)) begin
            failCount++;
            $display("[TB] FAIL r0_no_commit: got chk_we=%b wr=%0d, required 0 %0d", chkWe, wrCount, expWr);
        end
        writeCycle(5'd3, 32'd1);
        assertCount++;
        if (chkWe !== 1'b1 || chkData !== 32'd1) begin
            failCount++;
            $display("[TB] FAIL b2b_echo_first: got we=%b data=%h, required 1 1", chkWe, chkData);
        end
        writeCycle(5'd3, 32'd2);
        assertCount++;
        if (chkWe !== 1'b1 || chkWs !== 5'd3 || chkData !== 32'd2) begin
            failCount++;
            $display("[TB] FAIL b2b_echo_second: got we=%b ws=%0d data=%h, required 1 3 2", chkWe, chkWs, chkData);
        end
        rs1Addr = 5'd3;
        #1;
        assertCount++;
        if (rs1Data !== refMem[3]) begin
            failCount++;
            $display("[TB] FAIL b2b_last_wins: got %h, required %h", rs1Data, refMem[3]);
        end
        assertCount++;
        if (wrCount !== 16'(expWr)) begin
            failCount++;
            $display("[TB] FAIL b2b_count: got %0d, required %0d", wrCount, expWr);
        end
        step();
        assertCount++;
        if (chkWe !== 1'b0 || chkWs !== 5'd3 || chkData !== 32'd2) begin
            failCount++;
            $display("[TB] FAIL echo_hold: got we=%b ws=%0d data=%h, required 0 3 2", chkWe, chkWs, chkData);
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        doReset();
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        waitReady(cycles);
        assertCount++;
        if (cycles !== 32) begin
            failCount++;
            $display("[TB] FAIL midsweep_restart: got %0d cycles, required 32", cycles);
        end
        writeCycle(5'd4, 32'h00000055);
        writeCycle(5'd10, 32'hCAFEF00D);
        rs1Addr = 5'd4;
        s3We    = 1'b1;
        s3Ws    = 5'd12;
        s3Data  = 32'h0BADF00D;
        doReset();
        assertCount++;
        if (wrCount !== 16'd0 || dropCount !== 8'd0 || chkWe !== 1'b0 || ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midrun_reset: got wr=%0d drop=%0d chk_we=%b ready=%b, required 0 0 0 0",
                     wrCount, dropCount, chkWe, ready);
        end
        #1;
        assertCount++;
        if (rs1Data !== '0) begin
            failCount++;
            $display("[TB] FAIL midrun_clear_read: got %h, required 0", rs1Data);
        end
        waitReady(cycles);
        assertCount++;
        if (cycles !== 32) begin
            failCount++;
            $display("[TB] FAIL midrun_sweep_length: got %0d cycles, required 32", cycles);
        end
        for (int r = 1; r < NREGS; r++) begin
            rs1Addr = AW'(r);
            rs2Addr = AW'(NREGS - r);
            #1;
            assertCount++;
            if (rs1Data !== refMem[r] || rs2Data !== refMem[NREGS - r]) begin
                failCount++;
                $display("[TB] FAIL midrun_read_r%0d: got %h/%h, required %h/%h",
                         r, rs1Data, rs2Data, refMem[r], refMem[NREGS - r]);
            end
        end
    endtask

    initial begin
        $display("[TB] reg_file_wb bench start");
        test_reset();
        test_write_during_clear();
        test_write_echo();
        test_bypass();
        test_r0_back_to_back();
        test_reset_mid();
        step();
        assertCount++;
        if (echoQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL echo_outstanding: got %0d pending echoes, required 0", echoQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
